// File: rtl/la_filter_seq.sv
// la_filter_seq: sequencer for the boxcar averaging datapath.
// Generates the programmable sample strobe, flushes and refills the window
// after start, tags the strobes whose window sum is meaningful, and follows
// the adder-tree latency to publish a scaled, saturated average.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no strobes; waiting for start
//   FLUSH | strobe every cycle with zero samples to clear the window
//   FILL  | divided strobes with live samples until the window is full
//   RUN   | divided strobes; every strobe produces an average
module la_filter_seq #(
    parameter int DIV_W    = 8,
    parameter int WIN_LEN  = 128,
    parameter int TREE_LAT = 3,
    parameter int SUM_W    = 64,
    parameter int OUT_W    = 10
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [5:0]       cfg_shift,
    input  logic [OUT_W-1:0] adc_data,
    input  logic [SUM_W-1:0] sum_in,
    output logic             shift_en,
    output logic [OUT_W-1:0] sample_out,
    output logic [OUT_W-1:0] avg_out,
    output logic             avg_valid,
    output logic             win_full,
    output logic             busy
);

    localparam int CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        FILL  = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_lat;
    logic [5:0]          shift_lat;
    logic [DIV_W-1:0]    div_cnt;
    logic [DIV_W-1:0]    div_nxt;
    logic                strobe_nxt;
    logic [CNT_W-1:0]    flush_cnt;
    logic [CNT_W-1:0]    fill_cnt;
    logic [TREE_LAT-1:0] vld_pipe;
    logic                tag;
    logic                abort;
    logic [SUM_W-1:0]    scaled;
    logic [OUT_W-1:0]    sat_avg;

    // Divider lookahead: shift_en is registered, so it is decided from the
    // divider value the next cycle will hold.
    always_comb begin
        div_nxt    = (div_cnt == div_lat) ? '0 : div_cnt + DIV_W'(1);
        strobe_nxt = (div_nxt == div_lat);
    end

    // Tag strobes whose sum covers a full window, and detect a stop that
    // must abandon the current sequence.
    always_comb begin
        tag   = shift_en && ((state == RUN) || ((state == FILL) && (fill_cnt == WIN_LAST)));
        abort = stop && (state != IDLE);
    end

    // Scale the window sum and clamp it into the output width.
    always_comb begin
        scaled = '0;
        if (int'(shift_lat) < SUM_W) begin
            scaled = sum_in >> shift_lat;
        end
        sat_avg = (|scaled[SUM_W-1:OUT_W]) ? '1 : scaled[OUT_W-1:0];
    end

    // Sequencer FSM: config latch, flush/fill counting and strobe generation.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            div_lat    <= '0;
            shift_lat  <= '0;
            div_cnt    <= '0;
            flush_cnt  <= '0;
            fill_cnt   <= '0;
            shift_en   <= 1'b0;
            sample_out <= '0;
            win_full   <= 1'b0;
            busy       <= 1'b0;
        end else if (abort) begin
            state    <= IDLE;
            shift_en <= 1'b0;
            win_full <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    shift_en <= 1'b0;
                    if (start && !stop) begin
                        state      <= FLUSH;
                        busy       <= 1'b1;
                        flush_cnt  <= '0;
                        div_lat    <= cfg_div;
                        shift_lat  <= cfg_shift;
                        shift_en   <= 1'b1;
                        sample_out <= '0;
                    end
                end

                FLUSH: begin
                    flush_cnt <= flush_cnt + CNT_W'(1);
                    if (flush_cnt == WIN_LAST) begin
                        // With a zero divider the first live sample goes
                        // out in the very first FILL cycle.
                        state      <= FILL;
                        div_cnt    <= '0;
                        fill_cnt   <= '0;
                        shift_en   <= (div_lat == '0);
                        sample_out <= (div_lat == '0) ? adc_data : '0;
                    end else begin
                        shift_en   <= 1'b1;
                        sample_out <= '0;
                    end
                end

                FILL, RUN: begin
                    div_cnt  <= div_nxt;
                    shift_en <= strobe_nxt;
                    if (strobe_nxt) begin
                        sample_out <= adc_data;
                    end
                    if ((state == FILL) && shift_en) begin
                        fill_cnt <= fill_cnt + CNT_W'(1);
                        if (fill_cnt == WIN_LAST) begin
                            state    <= RUN;
                            win_full <= 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    shift_en <= 1'b0;
                    busy     <= 1'b0;
                    win_full <= 1'b0;
                end
            endcase
        end
    end

    // Valid pipeline matching adder-tree latency; loads the average when a
    // tagged strobe's sum arrives. A stop drops everything in flight.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_pipe  <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
        end else if (abort) begin
            vld_pipe  <= '0;
            avg_valid <= 1'b0;
        end else begin
            vld_pipe[0] <= tag;
            for (int i = 1; i < TREE_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
            avg_valid <= vld_pipe[TREE_LAT-1];
            if (vld_pipe[TREE_LAT-1]) begin
                avg_out <= sat_avg;
            end
        end
    end

endmodule

// File: tb/tb_la_filter_seq.sv
// Testbench for la_filter_seq: a behavioural 128-tap boxcar with a 3-cycle
// sum latency closes the loop; expected values are hand-derived constants.
module tb_la_filter_seq;

    localparam int WIN_LEN = 128;
    localparam int SUM_W   = 64;
    localparam int OUT_W   = 10;

    typedef struct {
        logic [5:0]       shift;
        logic [SUM_W-1:0] sum;
        logic [OUT_W-1:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             sys_rst_n;
    logic             start;
    logic             stop;
    logic [7:0]       cfg_div;
    logic [5:0]       cfg_shift;
    logic [OUT_W-1:0] adc_data;
    logic [SUM_W-1:0] sum_in = '0;
    logic             shift_en;
    logic [OUT_W-1:0] sample_out;
    logic [OUT_W-1:0] avg_out;
    logic             avg_valid;
    logic             win_full;
    logic             busy;

    int               cyc = 0;
    int               n_vec = 0;
    int               n_err = 0;
    logic             ramp_en = 1'b0;
    int               ramp_base = 0;
    logic [OUT_W-1:0] adc_const = '0;
    logic             ovr_en = 1'b0;
    logic [SUM_W-1:0] ovr_sum = '0;

    logic [OUT_W-1:0] win [WIN_LEN];
    int               wp = 0;
    logic [SUM_W-1:0] msum = '0;
    logic [SUM_W-1:0] sum_d1 = '0;
    logic [SUM_W-1:0] sum_d2 = '0;

    la_filter_seq dut (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .stop       (stop),
        .cfg_div    (cfg_div),
        .cfg_shift  (cfg_shift),
        .adc_data   (adc_data),
        .sum_in     (sum_in),
        .shift_en   (shift_en),
        .sample_out (sample_out),
        .avg_out    (avg_out),
        .avg_valid  (avg_valid),
        .win_full   (win_full),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC source: constant or a ramp equal to the cycle number since start
    always @(negedge clk) adc_data = ramp_en ? OUT_W'(cyc - ramp_base) : adc_const;

    // Boxcar filter model: sum visible 3 cycles after the strobe cycle
    always @(posedge clk) begin
        if (shift_en) begin
            msum    = msum - SUM_W'(win[wp]) + SUM_W'(sample_out);
            win[wp] = sample_out;
            wp      = (wp + 1) % WIN_LEN;
        end
        sum_d1 <= msum;
        sum_d2 <= sum_d1;
        sum_in <= ovr_en ? ovr_sum : sum_d2;
    end

    initial begin
        for (int i = 0; i < WIN_LEN; i++) win[i] = '0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_start(output int c);
        @(negedge clk);
        start = 1'b1;
        c = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin : main
        vec_t vt [12];
        int   c0;
        int   k;
        int   run_len;
        int   zbad;
        int   early;
        int   cnt;
        logic wf_a;
        logic wf_b;

        vt[0]  = '{6'd0,  64'd0,                  10'd0};
        vt[1]  = '{6'd0,  64'd1023,               10'd1023};
        vt[2]  = '{6'd0,  64'd1024,               10'd1023};
        vt[3]  = '{6'd0,  64'h8000_0000_0000_0001, 10'd1023};
        vt[4]  = '{6'd7,  64'd12800,              10'd100};
        vt[5]  = '{6'd1,  64'd12800,              10'd1023};
        vt[6]  = '{6'd3,  64'd5003,               10'd625};
        vt[7]  = '{6'd3,  64'd8191,               10'd1023};
        vt[8]  = '{6'd3,  64'd8192,               10'd1023};
        vt[9]  = '{6'd32, 64'h0000_0155_0000_0000, 10'd341};
        vt[10] = '{6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 10'd1};
        vt[11] = '{6'd63, 64'h7FFF_FFFF_FFFF_FFFF, 10'd0};

        // Reset with start held
        sys_rst_n = 1'b0;
        start     = 1'b1;
        stop      = 1'b0;
        cfg_div   = '0;
        cfg_shift = '0;
        adc_const = '0;
        repeat (3) @(negedge clk);
        check("rst_shift_en",   shift_en,   0);
        check("rst_sample_out", sample_out, 0);
        check("rst_avg_out",    avg_out,    0);
        check("rst_avg_valid",  avg_valid,  0);
        check("rst_win_full",   win_full,   0);
        check("rst_busy",       busy,       0);
        sys_rst_n = 1'b1;
        start     = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // div=2, constant 100, shift=1; config changes after start are ignored
        adc_const = 10'd100;
        cfg_div   = 8'd2;
        cfg_shift = 6'd1;
        do_start(c0);
        check("start_busy", busy, 1);
        cfg_div   = 8'd0;
        cfg_shift = 6'd7;
        run_len = 0;
        zbad    = 0;
        while (shift_en && run_len < 200) begin
            if (sample_out != '0) zbad++;
            run_len++;
            @(negedge clk);
        end
        check("flush_len",   run_len, 128);
        check("flush_zeros", zbad,    0);
        k = 0;
        while (!shift_en && k < 300) begin
            k++;
            @(negedge clk);
        end
        check("first_fill_strobe", cyc - c0, 131);
        early = 0;
        wf_a  = 1'b0;
        wf_b  = 1'b0;
        while (cyc < c0 + 516) begin
            if (cyc == c0 + 512) wf_a = win_full;
            if (cyc == c0 + 513) wf_b = win_full;
            if (avg_valid) early++;
            @(negedge clk);
        end
        check("win_full_last_fill", wf_a,  0);
        check("win_full_run",       wf_b,  1);
        check("no_early_valid",     early, 0);
        check("first_valid",        avg_valid, 1);
        check("sat_avg_shift1",     avg_out, 1023);
        wait_cycle(c0 + 517);
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            if (shift_en) cnt++;
            @(negedge clk);
        end
        check("run_period_latched", cnt, 3);
        do_stop();
        check("stop_idle", busy, 0);

        // Same sequence with shift=7 gives the true mean
        cfg_div   = 8'd2;
        cfg_shift = 6'd7;
        do_start(c0);
        cfg_shift = 6'd0;
        wait_cycle(c0 + 515);
        check("shift7_no_valid_early", avg_valid, 0);
        wait_cycle(c0 + 516);
        check("shift7_valid", avg_valid, 1);
        check("shift7_avg",   avg_out,   100);
        do_stop();

        // Ramp input, strobe every cycle, shift=7
        cfg_div   = 8'd0;
        cfg_shift = 6'd7;
        do_start(c0);
        ramp_base = c0;
        ramp_en   = 1'b1;
        wait_cycle(c0 + 256);
        check("ramp_win_full_fill", win_full, 0);
        wait_cycle(c0 + 259);
        check("ramp_no_valid_early", avg_valid, 0);
        for (int i = 0; i < 20; i++) begin
            wait_cycle(c0 + 260 + i);
            check("ramp_avg", {avg_valid, avg_out}, {1'b1, OUT_W'(191 + i)});
        end
        // stop two cycles after the strobe at c0+278
        wait_cycle(c0 + 280);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("ramp_stop_idle", busy, 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (avg_valid) cnt++;
            @(negedge clk);
        end
        check("ramp_stop_no_valid", cnt, 0);
        check("ramp_stop_avg_hold", avg_out, 211);
        ramp_en = 1'b0;

        // start and stop together in IDLE
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_busy",     busy,     0);
        check("start_stop_shift_en", shift_en, 0);

        // Asynchronous reset in the middle of FILL
        adc_const = 10'd100;
        cfg_div   = 8'd2;
        do_start(c0);
        wait_cycle(c0 + 200);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_shift_en",   shift_en,   0);
        check("midrst_sample_out", sample_out, 0);
        check("midrst_avg_out",    avg_out,    0);
        check("midrst_avg_valid",  avg_valid,  0);
        check("midrst_win_full",   win_full,   0);
        check("midrst_busy",       busy,       0);
        repeat (2) @(negedge clk);
        sys_rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (avg_valid || busy) cnt++;
        end
        check("midrst_quiet", cnt, 0);

        // Scaling / saturation table with the sum driven directly
        for (int i = 0; i < 12; i++) begin
            cfg_div   = 8'd0;
            cfg_shift = vt[i].shift;
            do_start(c0);
            cfg_shift = ~vt[i].shift;
            k = 0;
            while (!win_full && k < 400) begin
                k++;
                @(negedge clk);
            end
            check("vec_run_entry", win_full, 1);
            ovr_sum = vt[i].sum;
            ovr_en  = 1'b1;
            repeat (5) @(negedge clk);
            check($sformatf("vec%0d", i), {avg_valid, avg_out}, {1'b1, vt[i].exp});
            do_stop();
            ovr_en = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/la_filter_seq.md
Name: la_filter_seq

Overview:
- Sequencer for the 128-tap boxcar averaging datapath.
- Replaces the filter's hard-coded sample divider with a programmable sample strobe (`shift_en`).
- Flushes the window on start and suppresses outputs until the window is full.
- Tracks adder-tree latency and delivers a scaled, saturated average with a valid pulse to downstream separation logic.

Parameters:
- DIV_W, 8, width of clock-divider configuration
- WIN_LEN, 128, filter window length (taps)
- TREE_LAT, 3, cycles from `shift_en` cycle until `sum_in` reflects that sample
- SUM_W, 64, width of filter sum input
- OUT_W, 10, width of sample and average outputs

Ports:
- clk, in, 1, system clock
- sys_rst_n, in, 1, asynchronous active-low reset
- start, in, 1, pulse: begin flush/fill/run sequence
- stop, in, 1, pulse: abort to IDLE
- cfg_div, in, DIV_W, sample period minus 1, in clocks
- cfg_shift, in, 6, right-shift applied to `sum_in`
- adc_data, in, OUT_W, raw input sample
- sum_in, in, SUM_W, window sum from filter
- shift_en, out, 1, one-cycle strobe: filter shifts `sample_out` into window
- sample_out, out, OUT_W, sample presented to filter
- avg_out, out, OUT_W, scaled average
- avg_valid, out, 1, one-cycle pulse: `avg_out` updated
- win_full, out, 1, high in RUN
- busy, out, 1, high when state != IDLE

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; all counters 0; all outputs 0.
- Latched config: `div_lat`, `shift_lat` capture `cfg_div`/`cfg_shift` on the IDLE→FLUSH edge. Input changes are ignored until the next start.
- States:
  - IDLE: `shift_en`=0. `start`=1 → FLUSH, `flush_cnt`=0.
  - FLUSH: `shift_en`=1 every cycle, `sample_out`=0. `flush_cnt` increments. After WIN_LEN strobes → FILL, `div_cnt`=0, `fill_cnt`=0.
  - FILL: `div_cnt` counts 0..`div_lat`. When `div_cnt`==`div_lat`: `shift_en`=1 for that cycle, `div_cnt`←0, `fill_cnt`++. On the WIN_LEN-th FILL strobe → RUN.
  - RUN: same strobe generation; runs indefinitely.
- Strobe timing: first FILL strobe occurs `div_lat` cycles after FILL entry; strobe period is `div_lat`+1 clocks. `div_lat`=0 → strobe every cycle.
- Sample path: `sample_out` is registered; it updates with `adc_data` in the cycle `shift_en` rises (`sample_out` and `shift_en` are asserted together).
- Valid tagging: tag = `shift_en` AND (state==RUN OR the strobe is the final FILL strobe). FLUSH and earlier FILL strobes carry tag 0.
- Valid pipeline: tag enters a TREE_LAT-deep shift pipeline. At the clock edge ending cycle T+TREE_LAT (T = strobe cycle), `avg_out` is loaded and `avg_valid` is high for cycle T+TREE_LAT+1.
- Overlap: back-to-back strobes (`div_lat` < TREE_LAT) are handled by the pipeline; each tagged strobe yields exactly one `avg_valid`.
- Arithmetic: `scaled` = `sum_in` >> `shift_lat` (logical). If `scaled` > 2^OUT_W−1, `avg_out` = all ones; otherwise `avg_out` = `scaled[OUT_W-1:0]`. `shift_lat` ≥ SUM_W gives 0.
- `avg_out` holds its value between valid pulses.
- stop: from any non-IDLE state → IDLE on the next edge. The valid pipeline is cleared, so in-flight results never pulse. `avg_out` retains its last value.
- start and stop in the same cycle: stop wins. start while busy is ignored.
- Reset mid-operation: immediate return to reset values; no `avg_valid` pulse.

Test Plan:
- Reset with `start` held → all outputs 0; after release, one `start` → `busy`=1 next cycle, then exactly 128 consecutive `shift_en` with `sample_out`=0.
- `cfg_div`=2, `adc_data` constant 100, model filter with 3-cycle sum → `shift_en` every 3 clocks. First `avg_valid` occurs 4 cycles after the 128th FILL strobe, with `avg_out`=(12800>>1)=6400 saturated to 1023 for `cfg_shift`=1, and 100 for `cfg_shift`=7. No `avg_valid` before `win_full`.
- `cfg_div`=0, `cfg_shift`=7, ramp input → `avg_valid` every cycle in RUN; each `avg_out` equals the model window mean; result count equals RUN strobe count.
- `stop` asserted 2 cycles after a RUN strobe → no `avg_valid` for that strobe; IDLE next cycle; `avg_out` unchanged. `start`+`stop` in the same cycle in IDLE → stays IDLE.
- Change `cfg_div`/`cfg_shift` while in RUN → strobe period and scaling are unchanged until `stop`+`start`. Assert `sys_rst_n`=0 mid-FILL → all outputs 0 asynchronously.
